// File: rtl/edge_or_packer_if.sv
// Pixel-in / word-out handshake bundle for edge_or_packer.
// The slave modport is the packer's view; master is the upstream/downstream side.
interface edge_or_packer_if #(
  parameter int WORD_W = 8
) ();
  logic              in_valid;
  logic              bit_a;
  logic              bit_b;
  logic              in_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_valid,
    input  bit_a,
    input  bit_b,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_valid,
    output bit_a,
    output bit_b,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/edge_or_packer.sv
// ORs two serial edge-bit streams per pixel and packs them LSB-first into WORD_W-bit words.
// Optional EDGE_OR_COUNT_EN adds edge_count_o, the number of set pixels in the current frame.
module edge_or_packer #(
  parameter int NUM_PIXELS = 22500,
  parameter int WORD_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
`ifdef EDGE_OR_COUNT_EN
  output logic [14:0]     edge_count_o,
`endif
  edge_or_packer_if.slave bus
);

  localparam int CNT_W = 15;
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pixCount_q, pixCount_d;
  logic [IDX_W-1:0]  bitIdx_q, bitIdx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              shiftFull_q, shiftFull_d;
  logic              holdValid_q, holdValid_d;

  logic              inReady;
  logic              startAcc;
  logic              accept;
  logic              pix;
  logic              lastPix;
  logic              wordDone;
  logic              holdFree;
  logic [WORD_W-1:0] wordNext;

  assign lastPix = (pixCount_q == CNT_W'(NUM_PIXELS - 1));

  assign bus.in_ready  = inReady;
  assign bus.out_data  = hold_q;
  assign bus.out_valid = holdValid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pixCount_q  <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      shiftFull_q <= 1'b0;
      holdValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixCount_q  <= pixCount_d;
      bitIdx_q    <= bitIdx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      shiftFull_q <= shiftFull_d;
      holdValid_q <= holdValid_d;
    end
  end

  // A full shift register only blocks input while the holding register is still occupied.
  always_comb begin
    state_d  = state_q;
    inReady  = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    startAcc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          startAcc = 1'b1;
        end
      end
      RUN: begin
        busy_o  = 1'b1;
        inReady = ~(shiftFull_q & holdValid_q);
        if (inReady && bus.in_valid && lastPix) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        busy_o = 1'b1;
        if (holdValid_q && bus.out_ready && !shiftFull_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix         = bus.bit_a | bus.bit_b;
    accept      = inReady & bus.in_valid;
    wordDone    = accept & ((bitIdx_q == IDX_W'(WORD_W - 1)) | lastPix);
    holdFree    = ~holdValid_q | bus.out_ready;
    wordNext    = shift_q;
    wordNext[bitIdx_q] = pix;

    pixCount_d  = pixCount_q;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    shiftFull_d = shiftFull_q;
    holdValid_d = holdValid_q;

    if (holdValid_q && bus.out_ready) begin
      holdValid_d = 1'b0;
    end

    // A completed word skips the shift register when the holding register frees this cycle.
    if (startAcc) begin
      pixCount_d  = '0;
      bitIdx_d    = '0;
      shift_d     = '0;
      shiftFull_d = 1'b0;
    end else if (shiftFull_q && holdFree) begin
      hold_d      = shift_q;
      holdValid_d = 1'b1;
      shift_d     = '0;
      shiftFull_d = 1'b0;
    end else if (accept) begin
      pixCount_d = pixCount_q + CNT_W'(1);
      if (wordDone) begin
        bitIdx_d = '0;
        if (holdFree) begin
          hold_d      = wordNext;
          holdValid_d = 1'b1;
          shift_d     = '0;
        end else begin
          shift_d     = wordNext;
          shiftFull_d = 1'b1;
        end
      end else begin
        bitIdx_d = bitIdx_q + IDX_W'(1);
        shift_d  = wordNext;
      end
    end
  end

`ifdef EDGE_OR_COUNT_EN
  logic [14:0] edgeCount_q, edgeCount_d;

  always_comb begin
    edgeCount_d = edgeCount_q;
    if (startAcc) begin
      edgeCount_d = '0;
    end else if (accept && pix) begin
      edgeCount_d = edgeCount_q + 15'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edgeCount_q <= '0;
    end else begin
      edgeCount_q <= edgeCount_d;
    end
  end

  assign edge_count_o = edgeCount_q;
`endif

endmodule

// File: tb/tb_edge_or_packer.sv
// Randomized scoreboard bench for edge_or_packer; frames are shortened to keep runs brief.
// Expected words come from packing the OR of the generated bit arrays with plain arithmetic.
module tb_edge_or_packer;

  localparam int NP     = 100;
  localparam int W      = 8;
  localparam int NWORDS = (NP + W - 1) / W;

  localparam int MODE_RAND       = 0;
  localparam int MODE_SPARSE     = 1;
  localparam int MODE_ONES       = 2;
  localparam int MODE_STALL      = 3;
  localparam int MODE_COUNT      = 4;
  localparam int MODE_RAND_START = 5;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
`ifdef EDGE_OR_COUNT_EN
  logic [14:0] edgeCount;
`endif

  edge_or_packer_if #(.WORD_W(W)) ifc ();

  edge_or_packer #(
    .NUM_PIXELS (NP),
    .WORD_W     (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
`ifdef EDGE_OR_COUNT_EN
    .edge_count_o (edgeCount),
`endif
    .bus          (ifc)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int xfers      = 0;
  logic [W-1:0] expQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every word the DUT hands over must be the next one the model predicted.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ifc.out_valid && ifc.out_ready) begin
        xfers++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedWord", ifc.out_data, 32'hFFFF_FFFF);
        end else begin
          checkOutput("word", ifc.out_data, expQ.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input int mode, input int resetAt);
    bit a[NP];
    bit b[NP];
    int idx = 0;
    int cyc = 0;
    int ones = 0;
    int frameXfers;
    bit seenDone = 1'b0;
    bit endChecked = 1'b0;
    bit rnd;
    logic [W-1:0] word;

    rnd = (mode == MODE_RAND) || (mode == MODE_RAND_START);
    for (int i = 0; i < NP; i++) begin
      case (mode)
        MODE_SPARSE: begin a[i] = (i == 0); b[i] = (i == 9); end
        MODE_ONES:   begin a[i] = 1'b1; b[i] = 1'b1; end
        MODE_COUNT:  begin a[i] = (i % 2 == 0); b[i] = (i % 3 == 0); end
        default:     begin a[i] = 1'($urandom_range(0, 1)); b[i] = 1'($urandom_range(0, 1)); end
      endcase
      ones += int'(a[i] | b[i]);
    end
    for (int w = 0; w < NWORDS; w++) begin
      word = '0;
      for (int k = 0; k < W; k++) begin
        if (w * W + k < NP) word[k] = a[w * W + k] | b[w * W + k];
      end
      expQ.push_back(word);
    end
    frameXfers = xfers;

    @(posedge clk); #1;
    start = 1'b1;
    ifc.in_valid = 1'b0;
    while (!seenDone && cyc < 8 * NP + 200) begin
      @(posedge clk); #1;
      cyc++;
      start = (mode == MODE_RAND_START && (cyc == 20 || cyc == NP / 2));
      if (mode == MODE_STALL) ifc.out_ready = (cyc > 20);
      else if (rnd)           ifc.out_ready = ($urandom_range(0, 3) != 0);
      else                    ifc.out_ready = 1'b1;
      if (idx < NP) begin
        ifc.in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        ifc.bit_a    = a[idx];
        ifc.bit_b    = b[idx];
      end else begin
        ifc.in_valid = 1'b1;
        ifc.bit_a    = 1'($urandom_range(0, 1));
        ifc.bit_b    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (resetAt >= 0 && idx == resetAt) begin
        #1 rst = 1'b1;
        #1;
        checkOutput("asyncResetZero",
                    {ifc.in_ready, ifc.out_valid, busy, done, ifc.out_data}, 32'd0);
        expQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        ifc.in_valid = 1'b0;
        return;
      end
      if (idx == NP && !endChecked) begin
        checkOutput("inReadyAfterLast", ifc.in_ready, 32'd0);
        endChecked = 1'b1;
      end
      if (ifc.in_valid && ifc.in_ready && idx < NP) idx++;
      if (mode == MODE_STALL && cyc == 20) begin
        checkOutput("stallAccepted", idx, 32'd16);
        checkOutput("stallInReady", ifc.in_ready, 32'd0);
      end
      if (mode == MODE_STALL && (cyc == 21 || cyc == 22)) begin
        checkOutput("stallBackToBack", ifc.out_valid, 32'd1);
      end
      if (done) seenDone = 1'b1;
    end
    checkOutput("doneSeen", seenDone, 32'd1);

    @(posedge clk); #1;
    start = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("doneOnePulse", done, 32'd0);
    checkOutput("idleBusy", busy, 32'd0);
    checkOutput("wordsPerFrame", xfers - frameXfers, NWORDS);
    checkOutput("queueDrained", expQ.size(), 32'd0);
`ifdef EDGE_OR_COUNT_EN
    checkOutput("edgeCount", edgeCount, ones);
`endif
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.bit_a     = 1'b0;
    ifc.bit_b     = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetInReady", ifc.in_ready, 32'd0);
    checkOutput("resetOutValid", ifc.out_valid, 32'd0);
    checkOutput("resetOutData", ifc.out_data, 32'd0);
    checkOutput("resetBusyDone", {busy, done}, 32'd0);
    #1 rst = 1'b0;

    applyStimulus(MODE_SPARSE, -1);
    applyStimulus(MODE_ONES, -1);
    applyStimulus(MODE_STALL, -1);
    applyStimulus(MODE_RAND, 50);
    applyStimulus(MODE_RAND, -1);
    applyStimulus(MODE_RAND_START, -1);
    applyStimulus(MODE_COUNT, -1);
    for (int f = 0; f < 3; f++) applyStimulus(MODE_RAND, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
